// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word accesses onto a one-cycle-latency word memory, sub-word stores via read-modify-write.
// Latency: error 1, load 3, word store 2, sub-word store 4; req_ready only in IDLE, one request in flight.
module load_store_unit #(
    parameter int addresswidth = 32,
    parameter int width        = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [1:0]              req_size,
    input  logic                    req_signed,
    input  logic [addresswidth-1:0] req_addr,
    input  logic [width-1:0]        req_wdata,
    output logic                    resp_valid,
    output logic [width-1:0]        resp_rdata,
    output logic                    resp_misaligned,
    output logic [addresswidth-1:0] mem_address,
    output logic                    mem_writeEnable,
    output logic [width-1:0]        mem_dataIn,
    input  logic [width-1:0]        mem_dataOut
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD      = 3'd1;
    localparam logic [2:0] RD_WAIT = 3'd2;
    localparam logic [2:0] WR      = 3'd3;
    localparam logic [2:0] RESP    = 3'd4;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic [2:0]              state_q, state_d;
    logic [1:0]              lane_q, lane_d;
    logic [1:0]              size_q, size_d;
    logic                    signed_q, signed_d;
    logic                    write_q, write_d;
    logic [15:0]             wdata_q, wdata_d;
    logic                    err_q, err_d;
    logic [width-1:0]        rdata_q, rdata_d;
    logic [addresswidth-1:0] mem_address_q, mem_address_d;
    logic [width-1:0]        mem_data_in_q, mem_data_in_d;

    logic                    req_err;
    logic [7:0]              rd_byte;
    logic [15:0]             rd_half;
    logic [width-1:0]        load_val;
    logic [width-1:0]        merged;

    always_comb begin
        req_err = (req_size == 2'b11)
               || (req_size == SZ_HALF && req_addr[0])
               || (req_size == SZ_WORD && req_addr[1:0] != 2'b00);
    end

    // Lane extraction and merge share the latched low address bits.
    always_comb begin
        rd_byte = 8'h00;
        rd_half = 16'h0000;
        merged  = mem_dataOut;
        case (lane_q)
            2'd0: begin rd_byte = mem_dataOut[7:0];   merged[7:0]   = wdata_q[7:0]; end
            2'd1: begin rd_byte = mem_dataOut[15:8];  merged[15:8]  = wdata_q[7:0]; end
            2'd2: begin rd_byte = mem_dataOut[23:16]; merged[23:16] = wdata_q[7:0]; end
            default: begin rd_byte = mem_dataOut[31:24]; merged[31:24] = wdata_q[7:0]; end
        endcase
        rd_half = lane_q[1] ? mem_dataOut[31:16] : mem_dataOut[15:0];
        if (size_q == SZ_HALF) begin
            merged = mem_dataOut;
            if (lane_q[1]) merged[31:16] = wdata_q;
            else           merged[15:0]  = wdata_q;
        end else if (size_q == SZ_WORD) begin
            merged = mem_dataOut;
        end
        case (size_q)
            SZ_BYTE: load_val = {{(width-8){signed_q & rd_byte[7]}}, rd_byte};
            SZ_HALF: load_val = {{(width-16){signed_q & rd_half[15]}}, rd_half};
            default: load_val = mem_dataOut;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        lane_d        = lane_q;
        size_d        = size_q;
        signed_d      = signed_q;
        write_d       = write_q;
        wdata_d       = wdata_q;
        err_d         = err_q;
        rdata_d       = rdata_q;
        mem_address_d = mem_address_q;
        mem_data_in_d = mem_data_in_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    lane_d        = req_addr[1:0];
                    size_d        = req_size;
                    signed_d      = req_signed;
                    write_d       = req_write;
                    wdata_d       = req_wdata[15:0];
                    err_d         = req_err;
                    rdata_d       = '0;
                    mem_address_d = {2'b00, req_addr[addresswidth-1:2]};
                    if (req_err) begin
                        state_d = RESP;
                    end else if (req_write && req_size == SZ_WORD) begin
                        state_d       = WR;
                        mem_data_in_d = req_wdata;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD:      state_d = RD_WAIT;
            RD_WAIT: begin
                if (write_q) begin
                    mem_data_in_d = merged;
                    state_d       = WR;
                end else begin
                    rdata_d = load_val;
                    state_d = RESP;
                end
            end
            WR:      state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            lane_q        <= '0;
            size_q        <= '0;
            signed_q      <= 1'b0;
            write_q       <= 1'b0;
            wdata_q       <= '0;
            err_q         <= 1'b0;
            rdata_q       <= '0;
            mem_address_q <= '0;
            mem_data_in_q <= '0;
        end else begin
            state_q       <= state_d;
            lane_q        <= lane_d;
            size_q        <= size_d;
            signed_q      <= signed_d;
            write_q       <= write_d;
            wdata_q       <= wdata_d;
            err_q         <= err_d;
            rdata_q       <= rdata_d;
            mem_address_q <= mem_address_d;
            mem_data_in_q <= mem_data_in_d;
        end
    end

    assign req_ready       = (state_q == IDLE);
    assign resp_valid      = (state_q == RESP);
    assign resp_rdata      = resp_valid ? rdata_q : '0;
    assign resp_misaligned = resp_valid & err_q;
    assign mem_address     = mem_address_q;
    assign mem_writeEnable = (state_q == WR);
    assign mem_dataIn      = mem_data_in_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus random traffic against a byte-level memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misaligned;
    logic [31:0] mem_address;
    logic        mem_writeEnable;
    logic [31:0] mem_dataIn;
    logic [31:0] mem_dataOut;

    load_store_unit #(.addresswidth(32), .width(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_misaligned(resp_misaligned),
        .mem_address(mem_address), .mem_writeEnable(mem_writeEnable),
        .mem_dataIn(mem_dataIn), .mem_dataOut(mem_dataOut)
    );

    always #5 clk = ~clk;

    logic [31:0] dut_mem [0:15];
    logic [31:0] ref_mem [0:15];

    always @(posedge clk) begin
        if (mem_writeEnable) dut_mem[mem_address[3:0]] <= mem_dataIn;
        mem_dataOut <= dut_mem[mem_address[3:0]];
    end

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        int          cyc;
        logic        chk_mem;
        logic [3:0]  widx;
        logic [31:0] wword;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   wr_seen = 0;
    int   wr_exp = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, want);
        end
    endtask

    // Monitor: pops the scoreboard whenever the unit presents a response.
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_writeEnable) wr_seen++;
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp at cycle %0d got rdata %h expected no response", cyc, resp_rdata);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check32("resp_cycle", cyc, e.cyc);
                    check32("resp_rdata", resp_rdata, e.rdata);
                    check32("resp_misaligned", {31'd0, resp_misaligned}, {31'd0, e.mis});
                    if (e.chk_mem) check32("mem_word", dut_mem[e.widx], e.wword);
                end
            end
        end
    end

    // Reference model: memory treated as bytes at plain shift offsets.
    task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
        exp_t        e;
        int          n;
        int          sh;
        logic        err;
        logic [31:0] word, mask, lane;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout got req_ready %b expected 1", req_ready);
            return;
        end
        err  = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
        word = ref_mem[a[5:2]];
        sh   = 8 * int'(a[1:0]);
        mask = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
        e.rdata = 32'd0; e.mis = err; e.chk_mem = 1'b0; e.widx = a[5:2]; e.wword = 32'd0;
        if (err) begin
            e.cyc = cyc + 1;
        end else if (!w) begin
            e.cyc = cyc + 3;
            lane  = (word >> sh) & mask;
            if (sg && sz == 2'd0 && lane[7])  lane = lane | 32'hFFFF_FF00;
            if (sg && sz == 2'd1 && lane[15]) lane = lane | 32'hFFFF_0000;
            e.rdata = lane;
        end else begin
            e.cyc = cyc + ((sz == 2'd2) ? 2 : 4);
            word  = (word & ~(mask << sh)) | ((wd & mask) << sh);
            ref_mem[a[5:2]] = word;
            e.chk_mem = 1'b1;
            e.wword = word;
            wr_exp++;
        end
        exp_q.push_back(e);
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        @(negedge clk);
        // Junk while busy must be ignored.
        req_write = $urandom_range(0, 1); req_size = 2'($urandom_range(0, 3));
        req_addr = $urandom; req_wdata = $urandom;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            dut_mem[i] = 32'h0101_0101 * i;
            ref_mem[i] = 32'h0101_0101 * i;
        end
        dut_mem[5] = 32'h8899_AABB;
        ref_mem[5] = 32'h8899_AABB;
        reset = 1'b1;
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b11; req_signed = 1'b0;
        req_addr = 32'h13; req_wdata = 32'd0;
        @(negedge clk);
        @(negedge clk);
        check32("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check32("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check32("rst_resp_rdata", resp_rdata, 32'd0);
        check32("rst_misaligned", {31'd0, resp_misaligned}, 32'd0);
        check32("rst_mem_address", mem_address, 32'd0);
        check32("rst_mem_dataIn", mem_dataIn, 32'd0);
        check32("rst_mem_we", {31'd0, mem_writeEnable}, 32'd0);
        reset = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);

        issue(1'b0, 2'd2, 1'b0, 32'h14, 32'd0);
        issue(1'b0, 2'd0, 1'b1, 32'h17, 32'd0);
        issue(1'b0, 2'd0, 1'b0, 32'h17, 32'd0);
        issue(1'b0, 2'd1, 1'b1, 32'h16, 32'd0);
        issue(1'b1, 2'd0, 1'b0, 32'h15, 32'h1122_3344);
        issue(1'b0, 2'd2, 1'b0, 32'h14, 32'd0);
        issue(1'b0, 2'd1, 1'b0, 32'h13, 32'd0);
        issue(1'b1, 2'd3, 1'b0, 32'h10, 32'hFFFF_FFFF);
        issue(1'b1, 2'd2, 1'b0, 32'h21, 32'h1234_5678);

        // Reset lands on the RD_WAIT edge of a byte store.
        while (!req_ready) @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 32'h15; req_wdata = 32'h0000_00EE;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check32("abort_req_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        check32("abort_word5", dut_mem[5], ref_mem[5]);

        issue(1'b1, 2'd2, 1'b0, 32'h20, 32'hDEAD_BEEF);
        issue(1'b0, 2'd2, 1'b0, 32'h20, 32'd0);

        for (int t = 0; t < 300; t++) begin
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  32'($urandom_range(0, 63)), $urandom);
        end

        for (int n = 0; n < 100 && exp_q.size() != 0; n++) @(negedge clk);
        check32("drain_queue", exp_q.size(), 32'd0);
        @(negedge clk);
        check32("write_pulses", wr_seen, wr_exp);
        for (int i = 0; i < 16; i++) check32("final_mem", dut_mem[i], ref_mem[i]);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter addresswidth, default 32, byte-address width.
REQ-002 SHALL have parameter width, default 32, data word width; byte/half lane logic is defined for 32 only.
REQ-003 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  unit can accept a request this cycle.
REQ-007 SHALL have port req_write  input  1  1=store, 0=load.
REQ-008 SHALL have port req_size  input  2  00=byte, 01=half, 10=word, 11=reserved.
REQ-009 SHALL have port req_signed  input  1  sign-extend sub-word loads.
REQ-010 SHALL have port req_addr  input  addresswidth  byte address.
REQ-011 SHALL have port req_wdata  input  width  store data; the operand occupies the low bits.
REQ-012 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-013 SHALL have port resp_rdata  output  width  load result; 0 for stores and errors.
REQ-014 SHALL have port resp_misaligned  output  1  error flag, qualified by resp_valid.
REQ-015 SHALL have port mem_address  output  addresswidth  word index to the data memory.
REQ-016 SHALL have port mem_writeEnable  output  1  data memory write strobe.
REQ-017 SHALL have port mem_dataIn  output  width  data memory write word.
REQ-018 SHALL have port mem_dataOut  input  width  data memory read word; valid the cycle after mem_address is presented.

Function
REQ-019 SHALL implement states IDLE, RD, RD_WAIT, WR, RESP; req_ready SHALL be 1 only in IDLE.
REQ-020 SHALL accept a request on a rising edge with req_valid=1 in IDLE, latching addr, size, signed, write and wdata; request inputs are ignored in every other state.
REQ-021 SHALL flag a request as an error if req_size=11, if size=half and addr[0]=1, or if size=word and addr[1:0]!=00.
REQ-022 SHALL, for an error request, go IDLE->RESP without any memory read or write (latency 1).
REQ-023 SHALL drive mem_address = {2'b00, latched addr[addresswidth-1:2]} in every state after an accept.
REQ-024 SHALL drive mem_writeEnable=1 only in WR, for exactly one cycle per store.
REQ-025 SHALL, for a load, sequence IDLE->RD->RD_WAIT->RESP and extract the lane from mem_dataOut in RD_WAIT (latency 3).
REQ-026 SHALL, for a word store, sequence IDLE->WR->RESP with mem_dataIn=wdata (latency 2).
REQ-027 SHALL, for a byte/half store, perform read-modify-write IDLE->RD->RD_WAIT->WR->RESP (latency 4).
REQ-028 SHALL, in the read-modify-write RD_WAIT state, register the merge of mem_dataOut with the new lane, then drive that merged word on mem_dataIn in WR.
REQ-029 SHALL use little-endian lanes: byte k=bits[8k+7:8k] with k=addr[1:0]; half j=bits[16j+15:16j] with j=addr[1].
REQ-030 SHALL, on a load, zero-extend sub-word data if req_signed=0 and sign-extend if req_signed=1; signed is ignored for word size.
REQ-031 SHALL assert resp_valid=1 for exactly the one cycle in RESP, together with resp_rdata and resp_misaligned.
REQ-032 SHALL return RESP->IDLE unconditionally, so a new request is accepted no earlier than the cycle after the resp_valid pulse.
REQ-033 SHALL hold mem_dataIn at its last registered value when mem_writeEnable=0.

Reset
REQ-034 SHALL apply reset as state=IDLE, resp_valid=0, resp_rdata=0, resp_misaligned=0, mem_address=0, mem_dataIn=0, mem_writeEnable=0.
REQ-035 SHALL give reset priority over a simultaneous req_valid; no request is accepted in a reset cycle.
REQ-036 SHALL, on reset mid-operation, abandon the operation with no write strobe and no response; a pending WR is cancelled.

Verification (memory word 5 preloaded 0x8899AABB)
REQ-037 SHALL pass: word load addr 0x14 accepted cycle 0 -> resp_valid in cycle 3, rdata 0x8899AABB, misaligned 0.
REQ-038 SHALL pass: byte load addr 0x17 signed -> 0xFFFFFF88; unsigned -> 0x00000088; half load addr 0x16 signed -> 0xFFFF8899.
REQ-039 SHALL pass: byte store wdata 0x11223344 at addr 0x15 -> one write pulse in cycle 3, word 5 = 0x889944BB, resp_valid cycle 4.
REQ-040 SHALL pass: half load addr 0x13 -> resp_valid cycle 1, misaligned 1, rdata 0, no mem_writeEnable; same for req_size=11.
REQ-041 SHALL pass: reset asserted in RD_WAIT of a byte store -> no write, word 5 unchanged, no resp_valid, req_ready=1 after reset.
REQ-042 SHALL pass: word store 0xDEADBEEF to 0x20, then next-accepted load of 0x20 -> rdata 0xDEADBEEF.
